// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: one significand bit per cycle (shift-add),
// truncating normalisation, saturate on overflow, flush to +0 on underflow or zero inputs.
module fp_mul_seq #(
    parameter int BIAS  = 127,
    parameter int MBITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A_FP,
    input  logic [31:0] B_FP,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int PW = 2 * MBITS;
    localparam int CW = $clog2(MBITS);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       product_q, product_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [7:0]        ea_q, ea_d;
    logic [7:0]        eb_q, eb_d;
    logic [MBITS-1:0]  fa_q, fa_d;
    logic [MBITS-1:0]  fb_q, fb_d;
    logic [PW-1:0]     addend;

    // Exponent arithmetic is 10-bit signed so that both overflow past 254 and
    // underflow below 1 are visible before packing.
    function automatic logic [31:0] pack_result(input logic s, input logic [PW-1:0] p,
                                                input logic [7:0] ea, input logic [7:0] eb);
        logic signed [9:0] e;
        logic [MBITS-2:0]  mant;
        e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
        if (p[PW-1]) begin
            mant = p[PW-2 -: MBITS-1];
            e    = e + 10'sd1;
        end else begin
            mant = p[PW-3 -: MBITS-1];
        end
        if (e >= 10'sd255)
            pack_result = {s, 8'hFE, {(MBITS-1){1'b1}}};
        else if (e <= 10'sd0)
            pack_result = '0;
        else
            pack_result = {s, e[7:0], mant};
    endfunction

    assign addend = {{MBITS{1'b0}}, fa_q} << cnt_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = A_FP[31] ^ B_FP[31];
                    ea_d   = A_FP[30:23];
                    eb_d   = B_FP[30:23];
                    fa_d   = {1'b1, A_FP[MBITS-2:0]};
                    fb_d   = {1'b1, B_FP[MBITS-2:0]};
                    p_d    = '0;
                    cnt_d  = '0;
                    // Zero and subnormal operands complete immediately as +0.
                    if (A_FP[30:23] == 8'd0 || B_FP[30:23] == 8'd0) begin
                        product_d = '0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                if (fb_q[cnt_q])
                    p_d = p_q + addend;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MBITS - 1))
                    state_d = NORM;
            end
            NORM: begin
                product_d = pack_result(sign_q, p_q, ea_q, eb_q);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
        end
    end

    // Operand registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        ea_q   <= ea_d;
        eb_q   <= eb_d;
        fa_q   <= fa_d;
        fb_q   <= fb_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Sequential IEEE-754 single-precision multiplier that produces the products consumed by the `fp_add` accumulation stage of the CNN datapath. It forms each convolution term (pixel × weight) that the adder then sums. It uses a start/busy/done handshake and an iterative 24-cycle shift-add mantissa multiply. It does not round: it truncates, matching the adder's truncating normalisation, and uses the adder's +0 convention.

## Interface
Parameters:
- `BIAS`, default 127: exponent bias subtracted from the exponent sum.
- `MBITS`, default 24: significand width including the hidden 1. Sets the iteration count. The design is only verified at 24.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `A_FP`  in  32  operand A. Captured on the accepting edge.
- `B_FP`  in  32  operand B. Captured on the accepting edge.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when `product` is updated.
- `product`  out  32  result {sign, exponent[7:0], mantissa[22:0]}. Held until the next completion.

## Operation
- States: IDLE, MULT, NORM.
- IDLE with `start`=1:
  - Capture sign = A[31]^B[31], eA, eB, fa = {1,A[22:0]}, fb = {1,B[22:0]}.
  - Clear the 48-bit accumulator P and the 5-bit counter.
  - Set `busy`=1.
  - Go to MULT, or take the zero path.
- Zero path: if eA==0 or eB==0 (zero or subnormal, treated as zero):
  - On the accepting edge, load `product`=32'h00000000 (+0, sign forced 0) and pulse `done`.
  - Stay in IDLE with `busy`=0.
- MULT, one multiplier bit per cycle, LSB first:
  - If fb[cnt]=1, add fa<<cnt into P.
  - Increment cnt.
  - After MBITS iterations, go to NORM.
- NORM:
  - Compute e = eA+eB−BIAS as 10-bit signed.
  - If P[47]=1: mant = P[46:24], e = e+1. Otherwise mant = P[45:23].
  - No rounding; lower bits are dropped.
  - If e ≥ 255: saturate to {sign, 8'hFE, 23'h7FFFFF}. No inf or NaN is generated.
  - If e ≤ 0: underflow to 32'h00000000.
  - Otherwise: {sign, e[7:0], mant}.
  - Register `product`, pulse `done`, go to IDLE, set `busy`=0.
- Operands with exponent 255 (inf/NaN) are treated as ordinary numbers. The result saturates or underflows by the rules above.
- `start` while `busy`=1 is ignored. There is no queueing, and `A_FP`/`B_FP` may change freely.

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `done`=0, `product`=0, P=0, cnt=0.
- Reset during MULT or NORM aborts the operation. No `done` follows.
- Accepting edge = edge 0.
- Normal path:
  - MULT occupies edges 1..24.
  - The NORM edge is edge 25: `product` is valid and `done`=1 after it, and `busy`=0 after it.
  - Latency is 25 cycles from accept to `done`.
- Zero path: `done`=1 after edge 0. Latency is 1 cycle.
- `done` is high for exactly one cycle. It is cleared on the next edge unless a new completion occurs.
- Back-to-back: `start` high in the cycle where `done`=1 is accepted, because the state is IDLE. Throughput is one product per 26 cycles.
- `product` is stable from `done` until the next completion. The downstream negedge sampler therefore sees a settled value half a cycle after `done` rises.

## Test plan
- 0x40000000 × 0x40400000 (2×3), accepted at edge 0 → `done` after edge 25, `product`=0x40C00000, `busy` low in the same cycle.
- 0x3FC00000 × 0x3FC00000 (1.5²) → P[47] normalisation path, `product`=0x40100000. Also 0xC0000000 × 0x3F000000 → 0xBF800000.
- 0x00000000 × 0xC0400000 → `done` after edge 0, `product`=0x00000000 (+0), `busy` never high.
- 0x7F000000 × 0x7F000000 → 0x7F7FFFFF. Also 0x00800000 × 0x00800000 → 0x00000000 after the full 25 cycles.
- `start` pulsed again at edge 5 with different operands → ignored, and the first result is unchanged. `start` held high through `done` → the second operation is accepted on the `done` cycle and completes 25 cycles later.
- `rst` asserted mid-cycle during MULT (around edge 10) → outputs go to 0 immediately, with no `done` after release. A fresh 2×3 then yields 0x40C00000.
